// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = 15;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 deserialiser: input synchroniser, 16x tick generator and frame FSM.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUDRATE   = 115200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  byte_valid,
  output logic                  frame_err
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TCK_W = $clog2(OVERSAMPLE);

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [DIV_W-1:0]      div_cnt;
  logic                  b_tick;
  rx_state_t             state;
  logic [TCK_W-1:0]      tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  assign rx_s    = sync_q[1];
  assign b_tick  = (div_cnt == DIV_W'(DIV - 1));
  assign rx_byte = shreg;

  // Two-flop synchroniser, resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    if (reset)       div_cnt <= '0;
    else if (b_tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick_cnt == TCK_W'(MID_TICK)) begin
              // A start bit that is high again at mid-bit was a glitch.
              tick_cnt <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TCK_W'(1);
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick_cnt == TCK_W'(LAST_TICK)) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
              if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TCK_W'(1);
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (tick_cnt == TCK_W'(LAST_TICK)) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) byte_valid <= 1'b1;
              else      frame_err  <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TCK_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO and status pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUDRATE   = 115200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  rx_pop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic                  rx_done,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PTR_W = FIFO_AW + 1;

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  byte_valid;
  logic                  frame_err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  uart_rx_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop   = rx_pop && !rx_empty;
  // A pop in the same clk frees the slot, so a full FIFO still accepts the byte.
  assign do_push  = byte_valid && (!rx_full || do_pop);
  assign rx_data  = rx_empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      rx_done      <= byte_valid;
      rx_frame_err <= frame_err;
      rx_overrun   <= byte_valid && !do_push;
    end
  end

endmodule
